// File: rtl/clock_gen_ctrl.sv
// clock_gen_ctrl: programmable CPU clock generator with run / single-step /
// hold modes and one-cycle rise/fall ticks. mem_clock_out is a straight copy
// of clock_in for the instruction and data memories.
// Optional: define CLOCK_GEN_CYCLE_COUNT_EN to enable the cycle_count counter;
// otherwise cycle_count is tied to zero.
module clock_gen_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DEFAULT_HALF = 1
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    input  logic             step_req,
    output logic             clock_out,
    output logic             mem_clock_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             busy,
    output logic [31:0]      cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP_HI,
        S_STEP_LO,
        S_DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] w_half_m1;
    logic             r_clk;
    logic             w_clk_next;
    logic             r_rise;
    logic             w_rise_next;
    logic             r_fall;
    logic             w_fall_next;
    logic             r_step_prev;
    logic             w_step_edge;
    logic             w_at_end;
    logic             w_copy_half;
    logic             w_busy;

    assign w_half_m1   = r_half - ONE;
    assign w_at_end    = (r_cnt == w_half_m1);
    assign w_step_edge = step_req & ~r_step_prev;

    // State register
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-datapath decode; half_reg may only change at a
    // toggle boundary or while idle, so a running phase is never resized.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_clk_next   = r_clk;
        w_rise_next  = 1'b0;
        w_fall_next  = 1'b0;
        w_copy_half  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next  = '0;
                w_clk_next  = 1'b0;
                w_copy_half = 1'b1;
                if (mode == 2'b00) begin
                    w_state_next = S_RUN;
                end else if (mode == 2'b01 && w_step_edge) begin
                    w_state_next = S_STEP_HI;
                    w_clk_next   = 1'b1;
                    w_rise_next  = 1'b1;
                end
            end
            S_RUN: begin
                if (mode != 2'b00 && !r_clk) begin
                    // Stop while low: no pulse to protect, leave at once.
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (w_at_end) begin
                    w_cnt_next  = '0;
                    w_clk_next  = ~r_clk;
                    w_rise_next = ~r_clk;
                    w_fall_next = r_clk;
                    w_copy_half = 1'b1;
                    // Stop requested on the very edge the high phase ends.
                    if (mode != 2'b00) begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + ONE;
                    if (mode != 2'b00) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_at_end) begin
                    w_cnt_next   = '0;
                    w_clk_next   = 1'b0;
                    w_fall_next  = 1'b1;
                    w_copy_half  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + ONE;
                end
            end
            S_STEP_HI: begin
                if (w_at_end) begin
                    w_cnt_next   = '0;
                    w_clk_next   = 1'b0;
                    w_fall_next  = 1'b1;
                    w_copy_half  = 1'b1;
                    w_state_next = S_STEP_LO;
                end else begin
                    w_cnt_next = r_cnt + ONE;
                end
            end
            S_STEP_LO: begin
                if (w_at_end) begin
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + ONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_clk_next   = 1'b0;
            end
        endcase
    end

    // Output decode from state
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            S_STEP_HI, S_STEP_LO, S_DRAIN: w_busy = 1'b1;
            default:                       w_busy = 1'b0;
        endcase
    end

    // Counter, divided clock, ticks and step-edge history
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_cnt       <= '0;
            r_clk       <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_clk       <= w_clk_next;
            r_rise      <= w_rise_next;
            r_fall      <= w_fall_next;
            r_step_prev <= step_req;
        end
    end

    // Half-period registers: pending captures loads, half_reg adopts it
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_pending <= HALF_RST;
            r_half    <= HALF_RST;
        end else begin
            if (w_copy_half) begin
                r_half <= r_pending;
            end
            if (div_load) begin
                r_pending <= (div_value == '0) ? ONE : div_value;
            end
        end
    end

`ifdef CLOCK_GEN_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    // Count clock_out rising edges, wrapping naturally at 2^32
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_cycle_count <= '0;
        end else if (r_rise) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`else
    assign cycle_count = 32'd0;
`endif

    assign clock_out     = r_clk;
    assign rise_tick     = r_rise;
    assign fall_tick     = r_fall;
    assign busy          = w_busy;
    assign mem_clock_out = clock_in;

endmodule

// File: tb/tb_clock_gen_ctrl.sv
// Testbench for clock_gen_ctrl: directed scenarios plus a randomized run,
// all checked against a phase-level reference model.
module tb_clock_gen_ctrl;

    localparam int DEF_HALF = 1;
`ifdef CLOCK_GEN_CYCLE_COUNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        div_load;
    logic [31:0] div_value;
    logic        step_req;
    logic        clock_out;
    logic        mem_clock_out;
    logic        rise_tick;
    logic        fall_tick;
    logic        busy;
    logic [31:0] cycle_count;
    logic [3:0]  w_obs;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: phase kind (0 idle,1 run,2 step high,3 step low,
    // 4 draining), cycles left in the current phase, pending half-period.
    int          m_kind;
    int unsigned m_left;
    int unsigned m_pend;
    bit          m_clk, m_rise, m_fall, m_prev;
    bit [31:0]   m_cc;

    always #5 clk = ~clk;

    assign w_obs = {clock_out, rise_tick, fall_tick, busy};

    clock_gen_ctrl #(
        .CNT_W       (32),
        .DEFAULT_HALF(DEF_HALF)
    ) dut (
        .clock_in     (clk),
        .reset        (reset),
        .mode         (mode),
        .div_load     (div_load),
        .div_value    (div_value),
        .step_req     (step_req),
        .clock_out    (clock_out),
        .mem_clock_out(mem_clock_out),
        .rise_tick    (rise_tick),
        .fall_tick    (fall_tick),
        .busy         (busy),
        .cycle_count  (cycle_count)
    );

    function automatic logic [3:0] exp_bus();
        return {m_clk, m_rise, m_fall, (m_kind >= 2)};
    endfunction

    // Every new phase takes its length from the pending value seen at its start.
    task automatic model_step();
        bit stp_edge;
        if (reset) begin
            m_kind = 0; m_left = 0; m_pend = DEF_HALF;
            m_clk = 0; m_rise = 0; m_fall = 0; m_prev = 0; m_cc = 0;
        end else begin
            if (CC_EN && m_rise) m_cc = m_cc + 1;
            stp_edge = step_req && !m_prev;
            m_rise = 0;
            m_fall = 0;
            case (m_kind)
                0: begin
                    if (mode == 2'b00) begin
                        m_kind = 1; m_left = m_pend;
                    end else if (mode == 2'b01 && stp_edge) begin
                        m_kind = 2; m_clk = 1; m_rise = 1; m_left = m_pend;
                    end
                end
                1: begin
                    if (mode != 2'b00 && !m_clk) begin
                        m_kind = 0;
                    end else if (m_left == 1) begin
                        m_clk  = !m_clk;
                        m_rise = m_clk;
                        m_fall = !m_clk;
                        m_left = m_pend;
                        if (mode != 2'b00) m_kind = 0;
                    end else begin
                        m_left = m_left - 1;
                        if (mode != 2'b00) m_kind = 4;
                    end
                end
                2: begin
                    if (m_left == 1) begin
                        m_clk = 0; m_fall = 1; m_kind = 3; m_left = m_pend;
                    end else m_left = m_left - 1;
                end
                3: begin
                    if (m_left == 1) m_kind = 0;
                    else m_left = m_left - 1;
                end
                default: begin
                    if (m_left == 1) begin
                        m_clk = 0; m_fall = 1; m_kind = 0;
                    end else m_left = m_left - 1;
                end
            endcase
            if (div_load) m_pend = (div_value == 32'd0) ? 1 : div_value;
            m_prev = step_req;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1; mode = 2'b10; div_load = 0; div_value = 0; step_req = 0;
        repeat (3) tick();
        checks++;
        if (w_obs !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got=%b exp=0000", w_obs);
        end
        checks++;
        if (cycle_count !== 32'd0) begin
            errors++; $display("FAIL reset_count got=%0d exp=0", cycle_count);
        end
        checks++;
        if (mem_clock_out !== 1'b1) begin
            errors++; $display("FAIL mem_clock_high got=%b exp=1", mem_clock_out);
        end
        @(negedge clk); #1;
        checks++;
        if (mem_clock_out !== 1'b0) begin
            errors++; $display("FAIL mem_clock_low got=%b exp=0", mem_clock_out);
        end
    endtask

    task automatic test_run_default();
        reset = 1; tick();
        reset = 0; mode = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (clock_out !== 1'(i % 2) || rise_tick !== 1'(i % 2) || fall_tick !== 1'(i > 0 && i % 2 == 0)) begin
                errors++;
                $display("FAIL run_pattern cyc=%0d got clk=%b rise=%b fall=%b exp clk=%b", i, clock_out, rise_tick, fall_tick, 1'(i % 2));
            end
            checks++;
            if (w_obs !== exp_bus()) begin
                errors++; $display("FAIL run_model cyc=%0d got=%b exp=%b", cyc, w_obs, exp_bus());
            end
        end
    endtask

    task automatic test_div_load();
        int rises[$];
        int n = 0;
        while (clock_out !== 1'b1 && n < 4) begin tick(); n++; end
        checks++;
        if (clock_out !== 1'b1) begin
            errors++; $display("FAIL div_wait_high got=%b exp=1", clock_out);
        end
        div_load = 1; div_value = 3; tick();
        div_load = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rise_tick === 1'b1) rises.push_back(cyc);
            checks++;
            if (w_obs !== exp_bus()) begin
                errors++; $display("FAIL div_model cyc=%0d got=%b exp=%b", cyc, w_obs, exp_bus());
            end
        end
        checks++;
        if (rises.size() < 3) begin
            errors++; $display("FAIL div_rise_count got=%0d exp>=3", rises.size());
        end else if (rises[rises.size()-1] - rises[rises.size()-2] != 6) begin
            errors++; $display("FAIL div_rise_spacing got=%0d exp=6", rises[rises.size()-1] - rises[rises.size()-2]);
        end
    endtask

    task automatic test_step();
        int n_rise = 0, n_busy = 0, n_high = 0, n = 0;
        mode = 2'b10;
        tick();
        while ((busy !== 1'b0 || clock_out !== 1'b0) && n < 20) begin tick(); n++; end
        checks++;
        if (busy !== 1'b0 || clock_out !== 1'b0) begin
            errors++; $display("FAIL step_wait_idle got=%b exp=0000", w_obs);
        end
        div_load = 1; div_value = 2; tick();
        div_load = 0; mode = 2'b01; step_req = 0;
        repeat (2) tick();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 20; k++) begin
                step_req = (k == 0 || k == 2);
                tick();
                n_rise += int'(rise_tick === 1'b1);
                n_busy += int'(busy === 1'b1);
                n_high += int'(clock_out === 1'b1);
                checks++;
                if (w_obs !== exp_bus()) begin
                    errors++; $display("FAIL step_model cyc=%0d got=%b exp=%b", cyc, w_obs, exp_bus());
                end
            end
        end
        checks++;
        if (n_rise != 3 || n_busy != 12 || n_high != 6) begin
            errors++; $display("FAIL step_pulses got rise=%0d busy=%0d high=%0d exp 3/12/6", n_rise, n_busy, n_high);
        end
    endtask

    task automatic test_drain();
        int n = 0;
        logic exp_clk, exp_fall;
        div_load = 1; div_value = 4; mode = 2'b00; tick();
        div_load = 0;
        while (rise_tick !== 1'b1 && n < 30) begin tick(); n++; end
        checks++;
        if (rise_tick !== 1'b1) begin
            errors++; $display("FAIL drain_wait_rise got=%b exp=1", rise_tick);
        end
        mode = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_clk  = (i <= 3);
            exp_fall = (i == 4);
            checks++;
            if (clock_out !== exp_clk || fall_tick !== exp_fall || busy !== exp_clk || rise_tick !== 1'b0) begin
                errors++;
                $display("FAIL drain_seq i=%0d got=%b exp=%b%b%b%b", i, w_obs, exp_clk, 1'b0, exp_fall, exp_clk);
            end
            checks++;
            if (w_obs !== exp_bus()) begin
                errors++; $display("FAIL drain_model cyc=%0d got=%b exp=%b", cyc, w_obs, exp_bus());
            end
        end
    endtask

    task automatic test_zero_load();
        mode = 2'b10; div_load = 1; div_value = 0; tick();
        div_load = 0; tick();
        mode = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (clock_out !== 1'(i % 2) || w_obs !== exp_bus()) begin
                errors++; $display("FAIL zero_load i=%0d got=%b exp=%b", i, w_obs, exp_bus());
            end
        end
    endtask

    task automatic test_reset_mid_step();
        mode = 2'b10; tick(); tick();
        div_load = 1; div_value = 5; tick();
        div_load = 0; tick();
        mode = 2'b01; step_req = 0; tick();
        step_req = 1; tick();
        tick();
        checks++;
        if (clock_out !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL step_hi_entry got=%b exp=1001", w_obs);
        end
        reset = 1; tick();
        checks++;
        if (w_obs !== 4'b0000 || cycle_count !== 32'd0) begin
            errors++; $display("FAIL reset_mid_step got=%b cnt=%0d exp=0000 cnt=0", w_obs, cycle_count);
        end
        reset = 0; mode = 2'b00; step_req = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (clock_out !== 1'(i % 2) || w_obs !== exp_bus()) begin
                errors++; $display("FAIL half_after_reset i=%0d got=%b exp=%b", i, w_obs, exp_bus());
            end
        end
    endtask

    task automatic test_cycle_count();
        reset = 1; tick();
        reset = 0; mode = 2'b00;
        repeat (21) tick();
        checks++;
        if (cycle_count !== (CC_EN ? 32'd10 : 32'd0)) begin
            errors++; $display("FAIL cycle_count got=%0d exp=%0d", cycle_count, CC_EN ? 10 : 0);
        end
        checks++;
        if (cycle_count !== m_cc) begin
            errors++; $display("FAIL cycle_count_model got=%0d exp=%0d", cycle_count, m_cc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            div_load = ($urandom_range(0, 19) == 0);
            div_value = $urandom_range(0, 4);
            if ($urandom_range(0, 5) == 0) step_req = ~step_req;
            tick();
            checks++;
            if (w_obs !== exp_bus() || cycle_count !== m_cc) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b cnt=%0d exp=%b cnt=%0d", cyc, w_obs, cycle_count, exp_bus(), m_cc);
            end
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_run_default();
        test_div_load();
        test_step();
        test_drain();
        test_zero_load();
        test_reset_mid_step();
        test_cycle_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clock_gen_ctrl.md
Name: clock_gen_ctrl

Overview:
- Parametrised successor to the single-cycle computer's fixed toggle clock divider.
- Derives the CPU clock (clock_out) from the board clock with a run-time programmable half-period.
- Adds run, single-step and hold modes for debug, plus one-cycle edge ticks.
- mem_clock_out stays a direct pass-through of clock_in, feeding the instruction and data memories.

Parameters:
- CNT_W, 32, width of the half-period counter and of div_value.
- DEFAULT_HALF, 1, half-period (in clock_in cycles) loaded at reset. A value of 1 gives clock_in/2.

Ports:
- clock_in  input  1  board clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- mode  input  2  00 = RUN, 01 = STEP, 10/11 = HOLD.
- div_load  input  1  one-cycle strobe; captures div_value.
- div_value  input  CNT_W  new half-period. 0 is treated as 1.
- step_req  input  1  level from debounced key; each rising edge requests one step in STEP mode.
- clock_out  output  1  registered divided clock for the CPU.
- mem_clock_out  output  1  combinational copy of clock_in.
- rise_tick  output  1  high for exactly the cycle in which clock_out first reads 1.
- fall_tick  output  1  high for exactly the cycle in which clock_out first reads 0.
- busy  output  1  high while a step pulse is in progress or a stop is draining.
- cycle_count  output  32  number of clock_out rising edges; see Optional Feature.

Behaviour:
- Reset values: clock_out=0, rise_tick=0, fall_tick=0, busy=0, cnt=0, half_reg=DEFAULT_HALF, pending_half=DEFAULT_HALF, step_prev=0, state=IDLE, cycle_count=0.
- Half-period counter: cnt runs 0..half_reg-1. When cnt==half_reg-1: cnt<=0 and clock_out toggles, so each phase lasts exactly half_reg cycles.
- div_load:
  - pending_half <= (div_value==0 ? 1 : div_value).
  - Copied into half_reg at the next toggle boundary, or on the next cycle if state is IDLE.
  - A phase already in progress is never resized.
  - Back-to-back loads: the last one wins.
- States:
  - RUN: counter active, clock_out toggling continuously.
  - IDLE: clock_out=0, cnt held at 0.
  - STEP_HI, STEP_LO: one high phase then one low phase.
  - DRAIN: finishes the current high phase, then stops.
- Transitions:
  - IDLE to RUN when mode==00. The first rise occurs half_reg cycles after entry.
  - RUN with mode!=00:
    - If clock_out==0, go to IDLE next cycle with cnt<=0.
    - If clock_out==1, go to DRAIN and complete the high phase. clock_out falls on schedule (fall_tick=1), then IDLE.
  - A high pulse is never truncated.
  - IDLE with mode==01 and step_req rising edge (step_req & ~step_prev): next cycle clock_out=1, rise_tick=1, state STEP_HI.
  - STEP_HI to STEP_LO after half_reg cycles (clock_out falls).
  - STEP_LO to IDLE after half_reg cycles.
  - Step edges arriving while busy are ignored and not queued.
  - Mode change during STEP_HI/STEP_LO: the step completes, then the new mode is evaluated from IDLE.
- busy=1 in STEP_HI, STEP_LO and DRAIN; 0 otherwise.
- Ticks are registered alongside clock_out. They are never both high in the same cycle.
- With half_reg=1 in RUN: clock_out alternates every cycle and rise_tick/fall_tick alternate every cycle.
- Synchronous reset mid-operation (any state): all outputs return to reset values in the following cycle. pending_half and half_reg return to DEFAULT_HALF.
- cnt arithmetic is CNT_W-bit unsigned. The comparison uses half_reg-1, which is always ≥0 because half_reg≥1.

Optional Feature:
- Macro CLOCK_GEN_CYCLE_COUNT_EN.
- When defined: cycle_count increments by 1 on every cycle where rise_tick=1. It wraps from 0xFFFFFFFF to 0 and clears on reset.
- When undefined: no counter logic is instantiated and cycle_count is tied to 32'd0. The port list is unchanged.

Test Plan:
- Reset, mode=00, DEFAULT_HALF=1 -> clock_out pattern 0,1,0,1 from the first cycle after reset. rise_tick on every odd cycle. mem_clock_out equals clock_in.
- div_load with div_value=3 while in RUN mid-high-phase -> current phase keeps the old length. Thereafter clock_out is 3 high, 3 low (period 6). rise_tick spacing is 6.
- mode=01, three step_req rising edges separated by 20 cycles, half_reg=2 -> exactly three pulses, each 2 high/2 low. busy=1 for 4 cycles each. A step edge injected during busy produces no extra pulse.
- In RUN with half_reg=4, switch mode to 10 one cycle after a rise -> clock_out stays high 3 more cycles, falls (fall_tick=1), then holds 0. busy=1 during DRAIN.
- div_value=0 load -> behaves as half_reg=1. Reset asserted during STEP_HI -> next cycle clock_out=0, busy=0, half_reg=DEFAULT_HALF.
- With CLOCK_GEN_CYCLE_COUNT_EN defined, 10 RUN periods -> cycle_count=10. Without the macro, cycle_count stays 0.
